// File: rtl/wb_port.sv
// wb_port: writeback-side driver of the DLX register file's single write port.
//
// Two completion streams share the one write port:
//   - ALU results arrive with no backpressure. If a result cannot reach the
//     port at once it is held in a DEPTH-entry FIFO.
//   - Load results use a valid/ready handshake.
// A refused load is forced to win arbitration after MAX_WAIT refusals.
// When no result is granted the port drives Rd = 0, so the write lands on r0.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   alu_valid/rd/data   ALU completion stream
//   alu_stall           FIFO full; the pipeline must hold alu_valid low
//   mem_valid/rd/data   load completion stream
//   mem_ready           load accepted this cycle (combinational grant)
//   Rd, reg_in          registered register-file write index and data
//   overflow            sticky flag: a push into a full FIFO was dropped
//   pending_mask        (WB_PENDING_EN only) registered mask of destination
//                       registers held in the FIFO or on the current Rd
//
// Optional feature macro: WB_PENDING_EN
module wb_port #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_stall,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic [4:0]      Rd,
    output logic [XLEN-1:0] reg_in,
`ifdef WB_PENDING_EN
    output logic [31:0]     pending_mask,
`endif
    output logic            overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 2);

    logic [4:0]      fifo_rd_r   [DEPTH];
    logic [XLEN-1:0] fifo_data_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r, wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [WW-1:0]   wait_cnt_r;
    logic [4:0]      rd_r;
    logic [XLEN-1:0] data_r;
    logic            overflow_r;

    logic            fifo_empty_s, fifo_full_s;
    logic            alu_live_s, mem_live_s, alu_cand_s;
    logic            mem_win_s, head_win_s, direct_win_s;
    logic            push_s, push_ok_s, ovf_s, pop_s, mem_ready_s;
    logic [PW-1:0]   rd_ptr_nxt_s, wr_ptr_nxt_s;
    logic [CW-1:0]   count_nxt_s;
    logic [WW-1:0]   wait_nxt_s;
    logic [4:0]      rd_nxt_s;
    logic [XLEN-1:0] data_nxt_s;

    // Arbitration between the FIFO head, the incoming ALU result and the load,
    // plus the FIFO bookkeeping that follows from the grant.
    always_comb begin
        fifo_empty_s = (count_r == CW'(0));
        fifo_full_s  = (count_r == CW'(DEPTH));
        // Results aimed at r0 are never real candidates; reset masks all inputs.
        alu_live_s   = !reset && alu_valid && (alu_rd != 5'd0);
        mem_live_s   = !reset && mem_valid && (mem_rd != 5'd0);
        alu_cand_s   = !fifo_empty_s || alu_live_s;
        mem_win_s    = mem_live_s && (!alu_cand_s || (wait_cnt_r == WW'(MAX_WAIT)));
        head_win_s   = !reset && !mem_win_s && !fifo_empty_s;
        direct_win_s = !mem_win_s && fifo_empty_s && alu_live_s;
        // A live ALU result that did not go straight to the port must be queued.
        push_s       = alu_live_s && !direct_win_s;
        push_ok_s    = push_s && !fifo_full_s;
        ovf_s        = push_s && fifo_full_s;
        pop_s        = head_win_s;
        // Loads to r0 are acknowledged and discarded without using the port.
        mem_ready_s  = !reset && mem_valid && ((mem_rd == 5'd0) || mem_win_s);

        rd_nxt_s   = 5'd0;
        data_nxt_s = '0;
        if (mem_win_s) begin
            rd_nxt_s   = mem_rd;
            data_nxt_s = mem_data;
        end else if (head_win_s) begin
            rd_nxt_s   = fifo_rd_r[rd_ptr_r];
            data_nxt_s = fifo_data_r[rd_ptr_r];
        end else if (direct_win_s) begin
            rd_nxt_s   = alu_rd;
            data_nxt_s = alu_data;
        end else begin
            rd_nxt_s   = 5'd0;
            data_nxt_s = '0;
        end

        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        wr_ptr_nxt_s = push_ok_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase

        if (!mem_valid || mem_ready_s) begin
            wait_nxt_s = WW'(0);
        end else if (wait_cnt_r != WW'(MAX_WAIT)) begin
            wait_nxt_s = wait_cnt_r + WW'(1);
        end else begin
            wait_nxt_s = wait_cnt_r;
        end
    end

    // State update: FIFO storage and pointers, load wait counter, port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            wait_cnt_r <= '0;
            rd_r       <= 5'd0;
            data_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                fifo_rd_r[wr_ptr_r]   <= alu_rd;
                fifo_data_r[wr_ptr_r] <= alu_data;
            end
            rd_ptr_r   <= rd_ptr_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            count_r    <= count_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            rd_r       <= rd_nxt_s;
            data_r     <= data_nxt_s;
            if (ovf_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign alu_stall = fifo_full_s;
    assign mem_ready = mem_ready_s;
    assign Rd        = rd_r;
    assign reg_in    = data_r;
    assign overflow  = overflow_r;

`ifdef WB_PENDING_EN
    logic [31:0]   pend_nxt_s;
    logic [31:0]   pend_r;
    logic [PW-1:0] idx_s;
    logic [4:0]    ent_s;

    // Destination mask of the FIFO contents and Rd as they will stand after this edge.
    always_comb begin
        pend_nxt_s = 32'd0;
        idx_s      = '0;
        ent_s      = 5'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_nxt_s) begin
                idx_s = rd_ptr_nxt_s + PW'(k);
                // The slot being written this cycle is not yet in storage.
                if (push_ok_s && (idx_s == wr_ptr_r)) begin
                    ent_s = alu_rd;
                end else begin
                    ent_s = fifo_rd_r[idx_s];
                end
                pend_nxt_s[ent_s] = 1'b1;
            end else begin
                pend_nxt_s = pend_nxt_s;
            end
        end
        pend_nxt_s[rd_nxt_s] = 1'b1;
        pend_nxt_s[0]        = 1'b0;
    end

    // Registered pending mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r <= 32'd0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    assign pending_mask = pend_r;
`endif

endmodule

// File: tb/tb_wb_port.sv
// Testbench for wb_port. Instance a (MAX_WAIT = 3) has its port writes checked
// by a scoreboard queue and a negedge monitor; instance b (MAX_WAIT = 0, loads
// always win) is used for the FIFO-full, overflow and mid-operation reset cases.
module tb_wb_port;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a signals
    logic            a_reset, a_alu_valid, a_mem_valid;
    logic [4:0]      a_alu_rd, a_mem_rd, a_Rd;
    logic [XLEN-1:0] a_alu_data, a_mem_data, a_reg_in;
    logic            a_alu_stall, a_mem_ready, a_overflow;
    // Instance b signals
    logic            b_reset, b_alu_valid, b_mem_valid;
    logic [4:0]      b_alu_rd, b_mem_rd, b_Rd;
    logic [XLEN-1:0] b_alu_data, b_mem_data, b_reg_in;
    logic            b_alu_stall, b_mem_ready, b_overflow;

    wb_port #(.XLEN(XLEN), .DEPTH(4), .MAX_WAIT(3)) dut_a (
        .clk(clk), .reset(a_reset),
        .alu_valid(a_alu_valid), .alu_rd(a_alu_rd), .alu_data(a_alu_data),
        .alu_stall(a_alu_stall),
        .mem_valid(a_mem_valid), .mem_rd(a_mem_rd), .mem_data(a_mem_data),
        .mem_ready(a_mem_ready),
        .Rd(a_Rd), .reg_in(a_reg_in), .overflow(a_overflow)
    );

    wb_port #(.XLEN(XLEN), .DEPTH(4), .MAX_WAIT(0)) dut_b (
        .clk(clk), .reset(b_reset),
        .alu_valid(b_alu_valid), .alu_rd(b_alu_rd), .alu_data(b_alu_data),
        .alu_stall(b_alu_stall),
        .mem_valid(b_mem_valid), .mem_rd(b_mem_rd), .mem_data(b_mem_data),
        .mem_ready(b_mem_ready),
        .Rd(b_Rd), .reg_in(b_reg_in), .overflow(b_overflow)
    );

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];   // {rd, data} expected on instance a's port, in order

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every non-r0 write on instance a must match the scoreboard head.
    always @(negedge clk) begin
        if (a_Rd != 5'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", a_Rd, a_reg_in);
            end else begin
                check("port_write", {27'd0, a_Rd, a_reg_in}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        a_reset = 1'b1; a_alu_valid = 1'b0; a_alu_rd = 5'd0; a_alu_data = 32'd0;
        a_mem_valid = 1'b1; a_mem_rd = 5'd3; a_mem_data = 32'h33;
        b_reset = 1'b1; b_alu_valid = 1'b0; b_alu_rd = 5'd0; b_alu_data = 32'd0;
        b_mem_valid = 1'b0; b_mem_rd = 5'd0; b_mem_data = 32'd0;

        // Reset held two cycles; a load offered during reset must be ignored.
        #1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_mem_ready", 64'(a_mem_ready), 64'd0);
            check("reset_outputs", {27'd0, a_Rd, a_reg_in}, 64'd0);
        end
        a_reset = 1'b0; a_mem_valid = 1'b0; a_mem_rd = 5'd0;
        b_reset = 1'b0;

        // Idle five cycles.
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_state", {23'd0, a_Rd, a_reg_in, a_alu_stall, a_mem_ready, a_overflow}, 64'd0);
        end

        // ALU pass-through.
        a_alu_valid = 1'b1; a_alu_rd = 5'd5; a_alu_data = 32'h1234;
        exp_q.push_back({5'd5, 32'h1234});
        step();
        a_alu_valid = 1'b0; a_alu_rd = 5'd0; a_alu_data = 32'd0;
        check("pass_rd", 64'(a_Rd), 64'd5);
        check("pass_data", 64'(a_reg_in), 64'h1234);
        step();
        check("pass_one_cycle", 64'(a_Rd), 64'd0);

        // Load vs continuous ALU: refused three cycles, forced in on the fourth.
        for (int i = 1; i <= 3; i++) exp_q.push_back({5'(i), 32'h100 + 32'(i)});
        exp_q.push_back({5'd9, 32'hDEAD});
        for (int i = 4; i <= 6; i++) exp_q.push_back({5'(i), 32'h100 + 32'(i)});
        for (int i = 1; i <= 6; i++) begin
            a_alu_valid = 1'b1; a_alu_rd = 5'(i); a_alu_data = 32'h100 + 32'(i);
            a_mem_valid = (i <= 4); a_mem_rd = 5'd9; a_mem_data = 32'hDEAD;
            #1;
            check("contention_mem_ready", 64'(a_mem_ready), (i == 4) ? 64'd1 : 64'd0);
            step();
        end
        a_alu_valid = 1'b0; a_alu_rd = 5'd0; a_mem_valid = 1'b0; a_mem_rd = 5'd0;
        for (int i = 0; i < 5; i++) step();
        check("contention_drained", 64'(exp_q.size()), 64'd0);

        // r0 on both sources in the same cycle.
        a_alu_valid = 1'b1; a_alu_rd = 5'd0; a_alu_data = 32'hAAAA;
        a_mem_valid = 1'b1; a_mem_rd = 5'd0; a_mem_data = 32'hBBBB;
        #1;
        check("r0_mem_ready", 64'(a_mem_ready), 64'd1);
        step();
        a_alu_valid = 1'b0; a_mem_valid = 1'b0;
        check("r0_next_rd", 64'(a_Rd), 64'd0);
        step();
        check("r0_nothing_queued", {27'd0, a_Rd, a_reg_in}, 64'd0);

        // FIFO fill with loads winning every cycle (instance b).
        b_mem_valid = 1'b1; b_mem_rd = 5'd7; b_mem_data = 32'h77;
        for (int k = 0; k < 4; k++) begin
            b_alu_valid = 1'b1; b_alu_rd = 5'(10 + k); b_alu_data = 32'h200 + 32'(k);
            #1;
            check("full_mem_ready", 64'(b_mem_ready), 64'd1);
            check("full_stall_before", 64'(b_alu_stall), 64'd0);
            step();
            check("full_load_rd", 64'(b_Rd), 64'd7);
        end
        check("full_stall", 64'(b_alu_stall), 64'd1);
        check("full_no_overflow_yet", 64'(b_overflow), 64'd0);
        b_alu_rd = 5'd15; b_alu_data = 32'h2FF;
        step();
        b_alu_valid = 1'b0; b_alu_rd = 5'd0; b_mem_valid = 1'b0; b_mem_rd = 5'd0;
        check("overflow_set", 64'(b_overflow), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("drain_write", {27'd0, b_Rd, b_reg_in}, {27'd0, 5'(10 + k), 32'h200 + 32'(k)});
        end
        step();
        check("overflow_entry_dropped", 64'(b_Rd), 64'd0);
        check("overflow_sticky", 64'(b_overflow), 64'd1);
        check("drained_stall", 64'(b_alu_stall), 64'd0);

        // Mid-operation reset with three queued entries (instance b).
        b_mem_valid = 1'b1; b_mem_rd = 5'd7; b_mem_data = 32'h77;
        for (int k = 0; k < 3; k++) begin
            b_alu_valid = 1'b1; b_alu_rd = 5'(20 + k); b_alu_data = 32'h300 + 32'(k);
            step();
        end
        b_alu_valid = 1'b0; b_alu_rd = 5'd0;
        check("three_queued_no_stall", 64'(b_alu_stall), 64'd0);
        b_reset = 1'b1;
        #1;
        check("reset_blocks_ready", 64'(b_mem_ready), 64'd0);
        step();
        b_reset = 1'b0; b_mem_valid = 1'b0; b_mem_rd = 5'd0;
        check("midreset_rd", 64'(b_Rd), 64'd0);
        check("midreset_stall", 64'(b_alu_stall), 64'd0);
        check("midreset_overflow", 64'(b_overflow), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("midreset_discarded", {27'd0, b_Rd, b_reg_in}, 64'd0);
        end

        step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_port.md
Name: wb_port

Overview:
- Writeback-side driver of the DLX register file's single write port (`Rd`, `reg_in`), which writes `regs[Rd]` on every clock edge.
- Merges two completion streams onto that one port:
  - ALU/pipeline results, which arrive without backpressure and are buffered in a small FIFO.
  - Load results from the memory unit, which use a valid/ready handshake.
- When idle it drives `Rd = 0`, so the write lands on r0, which the register file always reads as 0.

Parameters:
- XLEN, 32, data width of results and `reg_in`.
- DEPTH, 4, ALU result FIFO entries (power of 2, ≥ 2).
- MAX_WAIT, 3, cycles a valid load may be refused before it is forced to win arbitration.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  destination register of ALU result.
- alu_data  in  XLEN  ALU result value.
- alu_stall  out  1  FIFO full; pipeline must hold `alu_valid` low while high.
- mem_valid  in  1  load result offered; held stable until accepted.
- mem_rd  in  5  load destination register.
- mem_data  in  XLEN  load value.
- mem_ready  out  1  load accepted this cycle (combinational grant).
- Rd  out  5  register file write index (registered).
- reg_in  out  XLEN  register file write data (registered).
- overflow  out  1  sticky error: push attempted into a full FIFO.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: `Rd = 0`, `reg_in = 0`, `overflow = 0`.
  - FIFO emptied, `wait_cnt = 0`.
  - While `reset` is high, `mem_ready = 0` and all inputs are ignored.
  - Reset mid-operation discards queued entries and any pending grant.
- r0 filtering:
  - An ALU result with `alu_rd = 0` is dropped: not enqueued, uses no port slot.
  - A load with `mem_rd = 0` gets `mem_ready = 1` at once and is discarded.
- ALU candidate each cycle: the FIFO head if the FIFO is non-empty, else the incoming ALU result if `alu_valid` and `alu_rd != 0`, else none.
- Grant (combinational from current state and inputs):
  - The load wins if `mem_valid`, `mem_rd != 0`, and either there is no ALU candidate or `wait_cnt == MAX_WAIT`. The load winning means `mem_ready = 1`.
  - Otherwise the ALU candidate wins.
  - If nothing wins, the next `Rd = 0` and `reg_in = 0`.
- Output latency: the winner is registered into `Rd`/`reg_in` at the end of the grant cycle, so the register file write occurs one edge later. Each result appears on the port for exactly one cycle.
- FIFO:
  - Push when `alu_valid`, `alu_rd != 0`, and the incoming result is not granted directly. This covers both a non-empty FIFO and a lost arbitration.
  - Pop when the head is granted.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pointers wrap modulo DEPTH. FIFO order is preserved.
- `alu_stall = (count == DEPTH)`, combinational.
- Overflow: a push into a full FIFO (protocol violation) is dropped and sets `overflow`. `overflow` is cleared only by reset.
- `wait_cnt`:
  - Increments, saturating at MAX_WAIT, each cycle a load with `mem_rd != 0` is refused.
  - Clears to 0 on load grant or when `mem_valid` is low.
- Ordering between ALU and load results to the same `Rd` is not enforced here; pipeline interlocks guarantee it. Within each source, order is preserved.
- Throughput: one register write per cycle maximum.

Optional Feature:
- Macro: WB_PENDING_EN.
- Defined:
  - Adds output `pending_mask`, 32 bits, registered.
  - Bit i is set iff a FIFO entry or the current `Rd` output targets register i.
  - Bit 0 is always 0. Reset value is all zeros.
  - Decode uses it as a scoreboard.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Hold `reset` 2 cycles, then no valids for 5 cycles.
  - Required: `Rd = 0`, `reg_in = 0`, `alu_stall = 0`, `mem_ready = 0`, `overflow = 0` throughout.
- ALU pass-through:
  - `alu_valid`, `rd = 5`, `data = 0x1234` in cycle N, FIFO empty.
  - Required: `Rd = 5`, `reg_in = 0x1234` in cycle N+1 only, then `Rd = 0`.
- Load vs ALU contention:
  - Continuous ALU results to rd 1..6 with `mem_valid`, `rd = 9`, `data = 0xDEAD`.
  - Required: load refused 3 cycles, `mem_ready = 1` on the 4th.
  - Required: the ALU result in that cycle is enqueued, and port order is 1, 2, 3, 9, 4, 5, 6.
- FIFO full and stall:
  - DEPTH = 4 with mem forced to win every cycle (`MAX_WAIT = 0`, `mem_valid` continuous); push 4 ALU results.
  - Required: `alu_stall = 1` after the 4th push.
  - Then inject `alu_valid` while stalled: required `overflow = 1` and the entry dropped.
- r0 handling:
  - `alu_rd = 0` plus `mem_valid` with `mem_rd = 0` in the same cycle.
  - Required: `mem_ready = 1`, nothing enqueued, next `Rd = 0`.
- Reset mid-operation:
  - FIFO holding 3 entries, assert `reset` 1 cycle.
  - Required: next cycle `Rd = 0`, queued results never appear, `alu_stall = 0`.
